// File: rtl/am2932_pkg.sv
// am2932 program control unit: opcodes, sequencer commands, FSM states,
// and command classification helpers shared by the sequencer files.
package am2932_pkg;

  localparam logic [3:0] PRST = 4'b0000;
  localparam logic [3:0] PSUS = 4'b0001;
  localparam logic [3:0] PSHD = 4'b0010;
  localparam logic [3:0] POPS = 4'b0011;
  localparam logic [3:0] FPC  = 4'b0100;
  localparam logic [3:0] FR   = 4'b0101;
  localparam logic [3:0] FSTK = 4'b0110;
  localparam logic [3:0] RTS  = 4'b0111;
  localparam logic [3:0] FD   = 4'b1000;
  localparam logic [3:0] FRD  = 4'b1001;
  localparam logic [3:0] FPCD = 4'b1010;
  localparam logic [3:0] JMPR = 4'b1011;
  localparam logic [3:0] JPPR = 4'b1100;
  localparam logic [3:0] JSBR = 4'b1101;
  localparam logic [3:0] JSBD = 4'b1110;
  localparam logic [3:0] PLDR = 4'b1111;

  localparam logic [2:0] CMD_FETCH = 3'd0;
  localparam logic [2:0] CMD_JMP   = 3'd1;
  localparam logic [2:0] CMD_JREL  = 3'd2;
  localparam logic [2:0] CMD_CALL  = 3'd3;
  localparam logic [2:0] CMD_RET   = 3'd4;
  localparam logic [2:0] CMD_PUSHD = 3'd5;
  localparam logic [2:0] CMD_POP   = 3'd6;
  localparam logic [2:0] CMD_RESET = 3'd7;

  typedef enum logic [1:0] {
    RST,
    IDLE,
    LDR,
    EXE
  } state_t;

  function automatic logic is_push(input logic [2:0] c);
    return (c == CMD_CALL) || (c == CMD_PUSHD);
  endfunction

  function automatic logic is_pop(input logic [2:0] c);
    return (c == CMD_RET) || (c == CMD_POP);
  endfunction

  // Commands that first load the R register via PLDR.
  function automatic logic two_phase(input logic [2:0] c);
    return (c == CMD_JMP) || (c == CMD_JREL) ||
           (c == CMD_CALL);
  endfunction

  // Opcode issued in the EXE cycle of a command.
  function automatic logic [3:0] op_of(input logic [2:0] c);
    logic [3:0] o;
    o = FPC;
    unique case (c)
      CMD_FETCH: o = FPC;
      CMD_JMP:   o = JMPR;
      CMD_JREL:  o = JPPR;
      CMD_CALL:  o = JSBR;
      CMD_RET:   o = RTS;
      CMD_PUSHD: o = PSHD;
      CMD_POP:   o = POPS;
      CMD_RESET: o = PRST;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/am2932_depth_trk.sv
// Mirror of the am2932 stack pointer with saturating push/pop, full/empty
// prediction for the acceptance guard, and the full_ consistency check.
// Ports: i_clk, i_rst_n (sync), i_clr, i_push, i_pop, i_chk, i_full_n,
//        o_depth, o_full_pred, o_empty_pred, o_err_sync.
module am2932_depth_trk #(
  parameter int DEPTH = 17
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_chk,
  input  logic       i_full_n,
  output logic [4:0] o_depth,
  output logic       o_full_pred,
  output logic       o_empty_pred,
  output logic       o_err_sync
);

  localparam logic [4:0] LP_DEPTH = 5'(DEPTH);

  logic [4:0] r_depth;
  logic [4:0] w_depth_nxt;
  logic       r_err_sync;
  logic       w_sync_bad;

  // Depth once the EXE currently in flight has completed.
  always_comb begin
    w_depth_nxt = r_depth;
    if (i_push && (r_depth != LP_DEPTH))
      w_depth_nxt = r_depth + 5'd1;
    else if (i_pop && (r_depth != 5'd0))
      w_depth_nxt = r_depth - 5'd1;
  end

  assign o_full_pred  = (w_depth_nxt == LP_DEPTH);
  assign o_empty_pred = (w_depth_nxt == 5'd0);

  // The slices only report full_, so a mismatch at the full
  // point is the only divergence visible from outside.
  assign w_sync_bad = i_chk &&
    ((r_depth == LP_DEPTH) != !i_full_n);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_depth    <= 5'd0;
      r_err_sync <= 1'b0;
    end else if (i_clr) begin
      r_depth    <= 5'd0;
      r_err_sync <= 1'b0;
    end else begin
      r_depth <= w_depth_nxt;
      if (w_sync_bad)
        r_err_sync <= 1'b1;
    end
  end

  assign o_depth    = r_depth;
  assign o_err_sync = r_err_sync;

endmodule

// File: rtl/am2932_seq_ctl.sv
// Command sequencer for a cascaded am2932 PC array: turns handshaked
// commands into PLDR/opcode sequences, drives D/ci, mirrors stack depth.
// Ports: cp, rst_ (sync, low), cmd_valid/cmd_ready/cmd/cmd_addr, full_,
//        i, d, d_oe_, ci, depth, err_ovf, err_unf, err_sync.
// Option AM2932_SEQ_CTL_HOLD_EN adds input hold (PSUS while idle).
module am2932_seq_ctl
  import am2932_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 17
) (
  input  logic         cp,
  input  logic         rst_,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd,
  input  logic [W-1:0] cmd_addr,
  input  logic         full_,
`ifdef AM2932_SEQ_CTL_HOLD_EN
  input  logic         hold,
`endif
  output logic [3:0]   i,
  output logic [W-1:0] d,
  output logic         d_oe_,
  output logic         ci,
  output logic [4:0]   depth,
  output logic         err_ovf,
  output logic         err_unf,
  output logic         err_sync
);

  state_t       r_state;
  state_t       w_state;
  logic [3:0]   r_i;
  logic [3:0]   w_i;
  logic [W-1:0] r_d;
  logic [W-1:0] w_d;
  logic         r_oe_n;
  logic         w_oe_n;
  logic         r_ci;
  logic         w_ci;
  logic         r_rdy;
  logic         w_rdy;
  logic [3:0]   r_op;
  logic [3:0]   w_op;
  logic         r_push;
  logic         w_push;
  logic         r_pop;
  logic         w_pop;
  logic         r_ovf;
  logic         r_unf;

  logic         w_acc;
  logic         w_clr;
  logic         w_hold;
  logic [2:0]   w_cmd;
  logic         w_ovf;
  logic         w_unf;
  logic         w_full_pred;
  logic         w_empty_pred;

`ifdef AM2932_SEQ_CTL_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_acc = cmd_valid & r_rdy;
  assign w_clr = w_acc && (cmd == CMD_RESET);

  am2932_depth_trk #(
    .DEPTH(DEPTH)
  ) u_trk (
    .i_clk       (cp),
    .i_rst_n     (rst_),
    .i_clr       (w_clr),
    .i_push      ((r_state == EXE) && r_push),
    .i_pop       ((r_state == EXE) && r_pop),
    .i_chk       (r_state == IDLE),
    .i_full_n    (full_),
    .o_depth     (depth),
    .o_full_pred (w_full_pred),
    .o_empty_pred(w_empty_pred),
    .o_err_sync  (err_sync)
  );

  // A stack command that would over/underflow degrades to FETCH.
  always_comb begin
    w_cmd = cmd;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (is_push(cmd) && w_full_pred) begin
      w_cmd = CMD_FETCH;
      w_ovf = 1'b1;
    end else if (is_pop(cmd) && w_empty_pred) begin
      w_cmd = CMD_FETCH;
      w_unf = 1'b1;
    end
  end

  always_comb begin
    w_state = IDLE;
    w_i     = FPC;
    w_d     = r_d;
    w_oe_n  = 1'b1;
    w_ci    = 1'b1;
    w_rdy   = 1'b1;
    w_op    = r_op;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    unique case (r_state)
      RST: begin
        w_state = IDLE;
      end
      LDR: begin
        w_state = EXE;
        w_i     = r_op;
        w_push  = r_push;
        w_pop   = r_pop;
      end
      IDLE, EXE: begin
        if (w_acc) begin
          w_op   = op_of(w_cmd);
          w_push = is_push(w_cmd);
          w_pop  = is_pop(w_cmd);
          if (two_phase(w_cmd)) begin
            w_state = LDR;
            w_i     = PLDR;
            w_d     = cmd_addr;
            w_oe_n  = 1'b0;
            w_ci    = 1'b0;
            w_rdy   = 1'b0;
          end else begin
            w_state = EXE;
            w_i     = op_of(w_cmd);
            if (w_cmd == CMD_PUSHD) begin
              w_d    = cmd_addr;
              w_oe_n = 1'b0;
            end
          end
        end
      end
    endcase
    // Suspend freezes the PC and tristates Y while idle.
    if ((w_state == IDLE) && w_hold) begin
      w_i   = PSUS;
      w_ci  = 1'b0;
      w_rdy = 1'b0;
    end
  end

  always_ff @(posedge cp) begin
    if (!rst_) begin
      r_state <= RST;
      r_i     <= PRST;
      r_d     <= '0;
      r_oe_n  <= 1'b1;
      r_ci    <= 1'b0;
      r_rdy   <= 1'b0;
      r_op    <= PRST;
      r_push  <= 1'b0;
      r_pop   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_i     <= w_i;
      r_d     <= w_d;
      r_oe_n  <= w_oe_n;
      r_ci    <= w_ci;
      r_rdy   <= w_rdy;
      r_op    <= w_op;
      r_push  <= w_push;
      r_pop   <= w_pop;
    end
  end

  always_ff @(posedge cp) begin
    if (!rst_) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_acc && w_ovf)
        r_ovf <= 1'b1;
      if (w_acc && w_unf)
        r_unf <= 1'b1;
    end
  end

  assign cmd_ready = r_rdy;
  assign i         = r_i;
  assign d         = r_d;
  assign d_oe_     = r_oe_n;
  assign ci        = r_ci;
  assign err_ovf   = r_ovf;
  assign err_unf   = r_unf;

endmodule

// File: tb/tb_am2932_seq_ctl.sv
// Directed bench for am2932_seq_ctl: hand-computed expectations
// checked with immediate assertions after each clock edge.
module tb_am2932_seq_ctl;

  logic        cp;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd;
  logic [15:0] cmd_addr;
  logic        full_;
`ifdef AM2932_SEQ_CTL_HOLD_EN
  logic        hold;
`endif
  logic [3:0]  i;
  logic [15:0] d;
  logic        d_oe_;
  logic        ci;
  logic [4:0]  depth;
  logic        err_ovf;
  logic        err_unf;
  logic        err_sync;

  int n_run;
  int n_fail;

  am2932_seq_ctl #(
    .W(16),
    .DEPTH(17)
  ) dut (
    .cp       (cp),
    .rst_     (rst_),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .cmd_addr (cmd_addr),
    .full_    (full_),
`ifdef AM2932_SEQ_CTL_HOLD_EN
    .hold     (hold),
`endif
    .i        (i),
    .d        (d),
    .d_oe_    (d_oe_),
    .ci       (ci),
    .depth    (depth),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_sync (err_sync)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst_      = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cmd_addr  = 16'h0;
    full_     = 1'b1;
`ifdef AM2932_SEQ_CTL_HOLD_EN
    hold      = 1'b0;
`endif

    // reset
    tick();
    tick();
    chk("rst_i", 32'(i), 32'h0);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_oe", 32'(d_oe_), 32'h1);
    chk("rst_ci", 32'(ci), 32'h0);
    chk("rst_rdy", 32'(cmd_ready), 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_errs", {29'h0, err_ovf, err_unf, err_sync}, 32'h0);
    rst_ = 1'b1;
    tick();
    chk("idle_i", 32'(i), 32'h4);
    chk("idle_ci", 32'(ci), 32'h1);
    chk("idle_rdy", 32'(cmd_ready), 32'h1);
    tick();
    tick();
    chk("idle3_i", 32'(i), 32'h4);
    chk("idle3_errs", {29'h0, err_ovf, err_unf, err_sync}, 32'h0);

    // JMP 1234
    cmd_valid = 1'b1;
    cmd       = 3'd1;
    cmd_addr  = 16'h1234;
    tick();
    cmd_valid = 1'b0;
    chk("jmp_ldr_i", 32'(i), 32'hF);
    chk("jmp_ldr_d", 32'(d), 32'h1234);
    chk("jmp_ldr_oe", 32'(d_oe_), 32'h0);
    chk("jmp_ldr_ci", 32'(ci), 32'h0);
    chk("jmp_ldr_rdy", 32'(cmd_ready), 32'h0);
    tick();
    chk("jmp_exe_i", 32'(i), 32'hB);
    chk("jmp_exe_ci", 32'(ci), 32'h1);
    chk("jmp_exe_rdy", 32'(cmd_ready), 32'h1);
    tick();
    chk("jmp_idle_i", 32'(i), 32'h4);

    // 17 back-to-back PUSHD, then an 18th
    cmd_valid = 1'b1;
    cmd       = 3'd5;
    for (int k = 0; k < 17; k++) begin
      cmd_addr = 16'(k);
      tick();
      chk($sformatf("push%0d_i", k), 32'(i), 32'h2);
      chk($sformatf("push%0d_d", k), 32'(d), 32'(k));
      chk($sformatf("push%0d_oe", k), 32'(d_oe_), 32'h0);
      chk($sformatf("push%0d_depth", k), 32'(depth), 32'(k));
    end
    cmd_addr = 16'd17;
    tick();
    cmd_valid = 1'b0;
    full_     = 1'b0;
    chk("push18_i", 32'(i), 32'h4);
    chk("push18_oe", 32'(d_oe_), 32'h1);
    chk("push18_ovf", 32'(err_ovf), 32'h1);
    chk("push18_depth", 32'(depth), 32'd17);
    tick();
    chk("full_idle_i", 32'(i), 32'h4);
    tick();
    chk("full_depth", 32'(depth), 32'd17);
    chk("full_sync", 32'(err_sync), 32'h0);
    full_ = 1'b1;
    tick();
    chk("bad_full_sync", 32'(err_sync), 32'h1);

    // RESET command clears errors, wins over sync mismatch
    cmd_valid = 1'b1;
    cmd       = 3'd7;
    tick();
    cmd_valid = 1'b0;
    chk("rcmd_i", 32'(i), 32'h0);
    chk("rcmd_depth", 32'(depth), 32'h0);
    chk("rcmd_errs", {29'h0, err_ovf, err_unf, err_sync}, 32'h0);
    tick();
    chk("rcmd_idle_i", 32'(i), 32'h4);

    // CALL 0100 then RET back-to-back
    cmd_valid = 1'b1;
    cmd       = 3'd3;
    cmd_addr  = 16'h0100;
    tick();
    cmd       = 3'd4;
    chk("call_ldr_i", 32'(i), 32'hF);
    chk("call_ldr_d", 32'(d), 32'h0100);
    tick();
    chk("call_exe_i", 32'(i), 32'hD);
    chk("call_exe_depth", 32'(depth), 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("ret_exe_i", 32'(i), 32'h7);
    chk("ret_exe_depth", 32'(depth), 32'h1);
    tick();
    chk("ret_idle_i", 32'(i), 32'h4);
    chk("ret_depth", 32'(depth), 32'h0);

    // POP at depth 0, then RESET command
    cmd_valid = 1'b1;
    cmd       = 3'd6;
    tick();
    chk("pop0_i", 32'(i), 32'h4);
    chk("pop0_unf", 32'(err_unf), 32'h1);
    chk("pop0_depth", 32'(depth), 32'h0);
    cmd = 3'd7;
    tick();
    cmd_valid = 1'b0;
    chk("pop_rcmd_i", 32'(i), 32'h0);
    chk("pop_rcmd_unf", 32'(err_unf), 32'h0);
    tick();

    // reset during the LDR of a CALL
    cmd_valid = 1'b1;
    cmd       = 3'd5;
    cmd_addr  = 16'hAAAA;
    tick();
    chk("pre_push_i", 32'(i), 32'h2);
    cmd       = 3'd3;
    cmd_addr  = 16'h0200;
    tick();
    cmd_valid = 1'b0;
    chk("abort_ldr_i", 32'(i), 32'hF);
    chk("abort_ldr_depth", 32'(depth), 32'h1);
    rst_ = 1'b0;
    tick();
    chk("abort_rst_i", 32'(i), 32'h0);
    chk("abort_rst_depth", 32'(depth), 32'h0);
    chk("abort_rst_rdy", 32'(cmd_ready), 32'h0);
    rst_ = 1'b1;
    tick();
    chk("abort_idle_i", 32'(i), 32'h4);
    tick();
    chk("abort_nojsbr_i", 32'(i), 32'h4);
    chk("abort_depth", 32'(depth), 32'h0);

`ifdef AM2932_SEQ_CTL_HOLD_EN
    hold = 1'b1;
    tick();
    chk("hold_i", 32'(i), 32'h1);
    chk("hold_ci", 32'(ci), 32'h0);
    chk("hold_rdy", 32'(cmd_ready), 32'h0);
    hold = 1'b0;
    tick();
    chk("unhold_i", 32'(i), 32'h4);
    chk("unhold_ci", 32'(ci), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/am2932_seq_ctl.md
Name: am2932_seq_ctl

Overview:
- Command sequencer for a cascaded am2932 program control unit: W/4 slices forming a W-bit PC with a shared 17-entry stack.
- Accepts high-level commands over a valid/ready handshake and issues the 4-bit am2932 instruction sequence to the slices.
- Drives the D bus and the incrementer carry-in, and keeps a mirror of the stack depth, because the am2932 has no empty_ output.
- Sits between microcode/decoder logic and the am2932 slice array.

Parameters:
- W, 16, PC/D width; must be a multiple of 4.
- DEPTH, 17, stack capacity; must equal the am2932 full point.

Ports:
- cp  input  1  clock; slices clock on the same edge.
- rst_  input  1  synchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready are both high at a rising cp edge.
- cmd  input  3  command code: 0 FETCH, 1 JMP, 2 JREL, 3 CALL, 4 RET, 5 PUSHD, 6 POP, 7 RESET.
- cmd_addr  input  W  operand for JMP/JREL/CALL/PUSHD.
- full_  input  1  wired-AND of the slices' full_ outputs.
- i  output  4  am2932 instruction, registered.
- d  output  W  D bus value, registered.
- d_oe_  output  1  D bus drive enable, active low.
- ci  output  1  incrementer carry-in to the LSB slice.
- depth  output  5  mirrored stack depth, 0..DEPTH.
- err_ovf, err_unf, err_sync  output  1 each  sticky error flags.

Behaviour:
- Reset (rst_=0 at a cp edge):
  - Next cycle: state RST, i=PRST (0000), d=0, d_oe_=1, ci=0, cmd_ready=0, depth=0, all errors cleared.
  - The first cycle with rst_=1 moves to IDLE.
  - Reset asserted mid-sequence (LDR or EXE) aborts it; no partial push or pop is counted.
- States: RST, IDLE, LDR, EXE. All outputs are registered.
  - IDLE: i=FPC (0100), ci=1 (sequential fetch), d_oe_=1.
  - LDR: i=PLDR (1111), d=operand, d_oe_=0, ci=0 (PC holds).
  - EXE: i=opcode for the command, ci=1; for PUSHD also d=operand, d_oe_=0.
- cmd_ready=1 in IDLE and EXE only, so single-cycle commands run back-to-back.
- Latency: accepted at edge N; one-phase commands show their opcode in cycle N+1; two-phase commands show PLDR in N+1 and the opcode in N+2.
- After EXE: a new accepted command goes to LDR or EXE as required, otherwise to IDLE.
- Command mapping:
  - FETCH: EXE FPC.
  - JMP: LDR, then EXE JMPR (1011).
  - JREL: LDR, then EXE JPPR (1100); the slice cn input is tied low.
  - CALL: LDR, then EXE JSBR (1101); push.
  - RET: EXE RTS (0111); pop.
  - PUSHD: EXE PSHD (0010); push.
  - POP: EXE POPS (0011); pop.
  - RESET: EXE PRST; depth<=0; errors cleared.
- Depth counter:
  - +1 at the end of an EXE that pushes; -1 at the end of an EXE that pops.
  - Never exceeds DEPTH and never goes below 0.
- Guarding, decided at acceptance:
  - Push command with depth==DEPTH: sets err_ovf; the command is replaced by FETCH, so no LDR/push is issued.
  - Pop command with depth==0: sets err_unf; replaced by FETCH.
  - Back-to-back pipelining: the guard uses the depth as it will be after the EXE in flight.
- Sync check, every cycle in IDLE: err_sync sets when (depth==DEPTH) != (full_==0).
- Error flags are sticky until reset or a RESET command. A RESET command takes precedence over the flag-set conditions in the same cycle.
- cmd_valid while cmd_ready=0: the command is held by the requester and not sampled.

Optional Feature:
- Macro AM2932_SEQ_CTL_HOLD_EN.
- When defined:
  - Adds input hold (1 bit, active high).
  - While hold=1 in IDLE: i=PSUS (0001), ci=0, cmd_ready=0, so the PC is frozen and Y is tristated.
  - hold is ignored in LDR/EXE; the sequence completes, then enters the hold state.
- When not defined: no port, and IDLE always issues FPC.

Decomposition:
- Package am2932_pkg:
  - The 16 am2932 opcode constants (PRST..PLDR).
  - Command code constants.
  - State typedef {RST, IDLE, LDR, EXE}.
  - Helper functions is_push(cmd), is_pop(cmd), two_phase(cmd).
- One sub-module, am2932_depth_trk:
  - Depth counter with saturating push/pop.
  - Produces full/empty predictions for the guard logic.
  - Performs the full_ consistency check.

Test Plan:
- Reset, then idle for 3 cycles -> i=0000 for one cycle, then 0100 with ci=1; depth=0; all error flags 0.
- JMP cmd_addr=16'h1234 -> i=1111 with d=1234 and d_oe_=0, next cycle i=1011; cmd_ready=0 during the LDR cycle.
- 17 back-to-back PUSHD (values 0..16), then an 18th -> depth reaches 17 and stays; 18th turns into FETCH with err_ovf=1; drive full_=0 at depth 17 -> err_sync stays 0.
- CALL 16'h0100 then RET, back-to-back -> i sequence 1111, 1101, 0111; depth goes 0 -> 1 -> 0.
- POP at depth 0 -> i=0100, err_unf=1; then RESET command -> i=0000, err_unf=0.
- rst_=0 during the LDR of a CALL -> next cycle i=0000, depth=0, no JSBR issued; with HOLD_EN, hold=1 in IDLE -> i=0001, ci=0.
